// File: rtl/modulo_output_pkg.sv
// Shared definitions for the output/display unit: seven-segment glyphs,
// main FSM states and BCD sizing.
package modulo_output_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_e;

  // Enough BCD digits to hold any unsigned value of the given bit width
  function automatic int bcd_digits(input int width);
    return (width + 2) / 3 + 1;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, WIDTH cycles
// after start; done marks the cycle carrying the final shift.
module bin2bcd_seq
  import modulo_output_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [WIDTH-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [4*bcd_digits(WIDTH)-1:0]  bcd
);

  localparam int DIGITS = bcd_digits(WIDTH);
  localparam int CW     = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic [3:0]          top_dig;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // The top digit never reaches 8, so only its low three bits survive the shift
  assign top_dig = bcd_q[4*DIGITS-4 +: 4];

  always_comb begin
    bcd_d    = '0;
    bcd_d[0] = sh_q[WIDTH-1];
    for (int i = 0; i < DIGITS - 1; i++)
      bcd_d[4*i+1 +: 4] = add3(bcd_q[4*i +: 4]);
    bcd_d[4*DIGITS-3 +: 3] = (top_dig >= 4'd5) ? top_dig[2:0] + 3'd3 : top_dig[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      sh_q   <= bin;
      bcd_q  <= '0;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      bcd_q <= bcd_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/modulo_output_v3.sv
// CPU output/display unit: captures OUT values, converts them to decimal for
// the seven-segment digits, refreshes a monitor channel and drives the LEDs.
module modulo_output_v3
  import modulo_output_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_DIGITS  = 4,
  parameter int MON_WIDTH   = 10,
  parameter int MON_DIGITS  = 2,
  parameter int LED_WIDTH   = 14,
  parameter int SIGNED_MODE = 1,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    out_valid,
  output logic                    out_ready,
  input  logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_enable_sw,
  input  logic                    in_enable,
  input  logic [MON_WIDTH-1:0]    mon_data,
  output logic [7*NUM_DIGITS-1:0] display_segs,
  output logic [7*MON_DIGITS-1:0] mon_segs,
  output logic [LED_WIDTH-1:0]    led,
  output logic                    overflow,
  output logic                    negative
);

  localparam int MD  = bcd_digits(DATA_WIDTH);
  localparam int MMD = bcd_digits(MON_WIDTH);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic signed [DATA_WIDTH-1:0] data_s;
  logic [DATA_WIDTH-1:0]   mag;
  logic                    is_neg;
  logic                    neg_q;
  logic [7*NUM_DIGITS-1:0] display_q;
  logic                    ovf_q, negative_q;
  logic [7*MON_DIGITS-1:0] mon_segs_q;
  logic                    mon_fmt_q;
  logic [LED_WIDTH-1:0]    led_q;
  logic                    main_start, main_busy, main_done;
  logic [4*MD-1:0]         main_bcd;
  logic                    mon_start, mon_busy, mon_done;
  logic [4*MMD-1:0]        mon_bcd;
  logic                    fmt_ovf;

  function automatic logic main_ovf(input logic [4*MD-1:0] bcd, input logic neg);
    logic o;
    o = 1'b0;
    // When negative, the top display position is reserved for the sign
    for (int i = 0; i < MD; i++)
      if (bcd[4*i +: 4] != 4'd0 && (i >= NUM_DIGITS || (neg && i == NUM_DIGITS - 1)))
        o = 1'b1;
    return o;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] main_segs(input logic [4*MD-1:0] bcd,
                                                        input logic neg, input logic ovf);
    logic [3:0]              dg [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] s;
    int                      msd;
    int                      sign_pos;
    msd = 0;
    for (int i = 0; i < NUM_DIGITS; i++) dg[i] = 4'd0;
    for (int i = 0; i < MD; i++)
      if (i < NUM_DIGITS) begin
        dg[i] = bcd[4*i +: 4];
        if (dg[i] != 4'd0) msd = i;
      end
    sign_pos = (BLANK_ZEROS != 0) ? msd + 1 : NUM_DIGITS - 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ovf)                                s[7*i +: 7] = SEG_E;
      else if (neg && i == sign_pos)          s[7*i +: 7] = SEG_MINUS;
      else if (BLANK_ZEROS != 0 && i > msd)   s[7*i +: 7] = SEG_BLANK;
      else                                    s[7*i +: 7] = seg_digit(dg[i]);
    end
    return s;
  endfunction

  function automatic logic [7*MON_DIGITS-1:0] mon_fmt(input logic [4*MMD-1:0] bcd);
    logic [3:0]              dg [MON_DIGITS];
    logic [7*MON_DIGITS-1:0] s;
    int                      msd;
    msd = 0;
    for (int i = 0; i < MON_DIGITS; i++) dg[i] = 4'd0;
    for (int i = 0; i < MMD; i++)
      if (i < MON_DIGITS) begin
        dg[i] = bcd[4*i +: 4];
        if (dg[i] != 4'd0) msd = i;
      end
    for (int i = 0; i < MON_DIGITS; i++)
      s[7*i +: 7] = (BLANK_ZEROS != 0 && i > msd) ? SEG_BLANK : seg_digit(dg[i]);
    return s;
  endfunction

  assign data_s = $signed(data_q);
  assign is_neg = (SIGNED_MODE != 0) && data_q[DATA_WIDTH-1];
  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
  assign mag    = is_neg ? $unsigned(-data_s) : data_q;

  assign main_start = (state_q == LOAD) && !main_busy;
  assign fmt_ovf    = main_ovf(main_bcd, neg_q);

  bin2bcd_seq #(.WIDTH(DATA_WIDTH)) u_main_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (main_start),
    .bin   (mag),
    .busy  (main_busy),
    .done  (main_done),
    .bcd   (main_bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (out_valid && out_enable_sw) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (main_done) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      neg_q      <= 1'b0;
      display_q  <= main_segs('0, 1'b0, 1'b0);
      ovf_q      <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && out_valid && out_enable_sw)
        data_q <= out_data;
      if (state_q == LOAD)
        neg_q <= is_neg;
      // Display and flags change together on the FORMAT edge
      if (state_q == FORMAT) begin
        display_q  <= main_segs(main_bcd, neg_q, fmt_ovf);
        ovf_q      <= fmt_ovf;
        negative_q <= neg_q;
      end
    end
  end

  // Free-running monitor: start, MON_WIDTH shifts, one format cycle
  assign mon_start = !mon_busy && !mon_fmt_q;

  bin2bcd_seq #(.WIDTH(MON_WIDTH)) u_mon_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mon_start),
    .bin   (mon_data),
    .busy  (mon_busy),
    .done  (mon_done),
    .bcd   (mon_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_fmt_q  <= 1'b0;
      mon_segs_q <= mon_fmt('0);
      led_q      <= '0;
    end else begin
      mon_fmt_q <= mon_done;
      if (mon_fmt_q)
        mon_segs_q <= mon_fmt(mon_bcd);
      led_q <= {out_enable_sw, in_enable ? out_data[LED_WIDTH-2:0] : {(LED_WIDTH-1){1'b0}}};
    end
  end

  assign out_ready    = (state_q == IDLE);
  assign display_segs = display_q;
  assign mon_segs     = mon_segs_q;
  assign led          = led_q;
  assign overflow     = ovf_q;
  assign negative     = negative_q;

endmodule

// File: tb/tb_modulo_output_v3.sv
// Directed bench for modulo_output_v3: a blanking instance and a non-blanking
// instance share the same stimulus.
module tb_modulo_output_v3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_enable_sw;
  logic        in_enable;
  logic [9:0]  mon_data;

  logic        out_ready, out_ready_nb;
  logic [27:0] display_segs, display_segs_nb;
  logic [13:0] mon_segs, mon_segs_nb;
  logic [13:0] led, led_nb;
  logic        overflow, overflow_nb;
  logic        negative, negative_nb;

  int n_chk  = 0;
  int n_fail = 0;
  int lows;

  always #5 clk = ~clk;

  modulo_output_v3 u_dut (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_enable_sw(out_enable_sw), .in_enable(in_enable),
    .mon_data(mon_data), .display_segs(display_segs), .mon_segs(mon_segs),
    .led(led), .overflow(overflow), .negative(negative)
  );

  modulo_output_v3 #(.BLANK_ZEROS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_ready(out_ready_nb),
    .out_data(out_data), .out_enable_sw(out_enable_sw), .in_enable(in_enable),
    .mon_data(mon_data), .display_segs(display_segs_nb), .mon_segs(mon_segs_nb),
    .led(led_nb), .overflow(overflow_nb), .negative(negative_nb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!out_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", out_ready, 1'b1);
  endtask

  // Returns at the first falling edge after the accept edge
  task automatic send(input logic [31:0] v);
    wait_ready();
    @(negedge clk);
    out_valid = 1'b1;
    out_data  = v;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!out_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_valid = 1'b0; out_data = '0; out_enable_sw = 1'b0;
    in_enable = 1'b0; mon_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready",    out_ready, 1'b1);
    check("rst_disp",     display_segs, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("rst_disp_nb",  display_segs_nb, {7'h40, 7'h40, 7'h40, 7'h40});
    check("rst_led",      led, 14'h0);
    check("rst_ovf",      overflow, 1'b0);
    check("rst_neg",      negative, 1'b0);
    check("rst_mon",      mon_segs, {7'h7F, 7'h40});

    // 1234 and busy length
    out_enable_sw = 1'b1;
    send(32'd1234);
    count_busy(lows);
    check("busy_cycles_1234", lows, 34);
    check("disp_1234",    display_segs, {7'h79, 7'h24, 7'h30, 7'h19});
    check("disp_1234_nb", display_segs_nb, {7'h79, 7'h24, 7'h30, 7'h19});
    check("ovf_1234",     overflow, 1'b0);

    // Switch off: strobe ignored
    out_enable_sw = 1'b0;
    out_valid = 1'b1; out_data = 32'd999;
    @(negedge clk);
    out_valid = 1'b0;
    check("sw_off_ready", out_ready, 1'b1);
    repeat (40) @(negedge clk);
    check("sw_off_disp",  display_segs, {7'h79, 7'h24, 7'h30, 7'h19});
    out_enable_sw = 1'b1;

    // -42
    send(32'hFFFF_FFD6);
    count_busy(lows);
    check("busy_cycles_m42", lows, 34);
    check("disp_m42",     display_segs, {7'h7F, 7'h3F, 7'h19, 7'h24});
    check("disp_m42_nb",  display_segs_nb, {7'h3F, 7'h40, 7'h19, 7'h24});
    check("neg_m42",      negative, 1'b1);
    check("ovf_m42",      overflow, 1'b0);

    // Overflow cases
    send(32'd10000);
    count_busy(lows);
    check("disp_10000",   display_segs, {4{7'h06}});
    check("disp_10000_nb", display_segs_nb, {4{7'h06}});
    check("ovf_10000",    overflow, 1'b1);
    check("neg_10000",    negative, 1'b0);
    send(32'hFFFF_FC18);
    count_busy(lows);
    check("ovf_m1000",    overflow, 1'b1);
    check("disp_m1000",   display_segs, {4{7'h06}});
    check("neg_m1000",    negative, 1'b1);
    send(32'h8000_0000);
    count_busy(lows);
    check("ovf_minint",   overflow, 1'b1);
    check("neg_minint",   negative, 1'b1);
    send(32'd5);
    count_busy(lows);
    check("disp_5",       display_segs, {7'h7F, 7'h7F, 7'h7F, 7'h12});
    check("disp_5_nb",    display_segs_nb, {7'h40, 7'h40, 7'h40, 7'h12});
    check("ovf_5",        overflow, 1'b0);
    check("neg_5",        negative, 1'b0);

    // Strobe during conversion is dropped
    send(32'd1234);
    repeat (9) @(negedge clk);
    out_valid = 1'b1; out_data = 32'd77;
    @(negedge clk);
    out_valid = 1'b0;
    count_busy(lows);
    check("overlap_disp", display_segs, {7'h79, 7'h24, 7'h30, 7'h19});
    repeat (3) @(negedge clk);
    check("overlap_noqueue", out_ready, 1'b1);

    // Reset in the middle of a conversion
    send(32'd4321);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", out_ready, 1'b1);
    check("midrst_disp",  display_segs, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("midrst_led",   led, 14'h0);
    check("midrst_ovf",   overflow, 1'b0);
    check("midrst_neg",   negative, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Monitor channel
    mon_data = 10'd1023;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (mon_segs == {7'h24, 7'h30}) break;
    end
    check("mon_1023", mon_segs, {7'h24, 7'h30});
    mon_data = 10'd5;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (mon_segs == {7'h7F, 7'h12}) break;
    end
    check("mon_5",    mon_segs, {7'h7F, 7'h12});
    check("mon_5_nb", mon_segs_nb, {7'h40, 7'h12});

    // LEDs
    in_enable = 1'b1; out_data = 32'h0000_1ABC; out_enable_sw = 1'b1;
    @(negedge clk);
    check("led_in", led, 14'h3ABC);
    in_enable = 1'b0;
    @(negedge clk);
    check("led_no_in", led, 14'h2000);
    out_enable_sw = 1'b0;
    @(negedge clk);
    check("led_sw_off", led, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
